// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
// Shared types and helpers for the serializer_stream block.
//   state_t    : shifter FSM states (IDLE, SHIFT)
//   len_decode : converts a data_mod field into a bit count (0 means full word)
//   legal_len  : tells whether a data_mod field describes a word that may be sent
// ---------------------------------------------------------------------------
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A zero length field stands for a full-width word.
  function automatic int unsigned len_decode(input int unsigned mod, input int unsigned dataW);
    return (mod == 0) ? dataW : mod;
  endfunction

  // Lengths 1..minLen-1 are too short for the downstream encoders and get dropped.
  function automatic logic legal_len(input int unsigned mod, input int unsigned minLen);
    return (mod == 0) || (mod >= minLen);
  endfunction

endpackage

// File: rtl/serializer_stream_hold_reg.sv
// ---------------------------------------------------------------------------
// ser_hold_reg
// One-entry holding register for a queued word together with its length
// field and bit order, so the next word can wait while the current one shifts.
// Ports:
//   clk_i, arst_n_i        : clock, asynchronous active-low reset
//   wr_i                   : store data_i/mod_i/msb_i, entry becomes full
//   rd_i                   : entry is taken by the shifter, becomes empty
//   data_i, mod_i, msb_i   : word, length field and bit order to store
//   data_o, mod_o, msb_o   : stored word, length field and bit order
//   full_o                 : entry holds a valid word
// ---------------------------------------------------------------------------
module ser_hold_reg #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  mod_i,
  input  logic              msb_i,
  output logic [DATA_W-1:0] data_o,
  output logic [MOD_W-1:0]  mod_o,
  output logic              msb_o,
  output logic              full_o
);

  logic [DATA_W-1:0] data_q;
  logic [MOD_W-1:0]  mod_q;
  logic              msb_q;
  logic              full_q;
  logic              full_d;

  // A write wins over a read in the same cycle: the old word leaves, the new one stays.
  assign full_d = wr_i ? 1'b1 : (rd_i ? 1'b0 : full_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q <= '0;
      mod_q  <= '0;
      msb_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_i) begin
        data_q <= data_i;
        mod_q  <= mod_i;
        msb_q  <= msb_i;
      end
    end
  end

  assign data_o = data_q;
  assign mod_o  = mod_q;
  assign msb_o  = msb_q;
  assign full_o = full_q;

endmodule

// File: rtl/serializer_stream.sv
// ---------------------------------------------------------------------------
// serializer_stream
// Parallel-to-serial converter with ready/valid handshakes on both sides.
// Words of DATA_W bits with a per-word length are sent one bit per cycle,
// MSB-first or LSB-first, with a marker on the final bit. A one-word hold
// register lets the next word wait so consecutive words leave without gaps.
// Ports:
//   clk_i, arst_n_i  : clock, asynchronous active-low reset
//   data_i           : parallel word
//   data_mod_i       : bit count, 0 means DATA_W bits
//   msb_first_i      : 1 = data_i[DATA_W-1] first, 0 = data_i[0] first
//   data_val_i       : input word valid
//   data_ready_o     : input ready (low only while the hold register is full)
//   ser_data_o       : serial bit
//   ser_data_val_o   : serial bit valid
//   ser_last_o       : final bit of the current word
//   ser_ready_i      : downstream ready
//   busy_o           : shifter active or hold register occupied
//   drop_o           : one-cycle pulse after accepting an illegal-length word
// ---------------------------------------------------------------------------
module serializer_stream
  import serializer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  input  logic              ser_ready_i,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Hold register interface
  logic              holdWr;
  logic              holdRd;
  logic              holdFull;
  logic [DATA_W-1:0] holdData;
  logic [MOD_W-1:0]  holdMod;
  logic              holdMsb;

  // Shifter state and registered outputs
  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  remain_q;
  logic              msb_q;
  logic              serData_q;
  logic              serVal_q;
  logic              serLast_q;
  logic              drop_q;

  // Handshake and load decisions
  logic              inFire;
  logic              inLegal;
  logic              wordEnd;
  logic              slotFree;
  logic              loadHold;
  logic              loadIn;
  logic              stepBit;

  // Word selected for loading and its first-bit/shift views
  logic [DATA_W-1:0] srcData;
  logic [MOD_W-1:0]  srcMod;
  logic              srcMsb;
  logic [CNT_W-1:0]  srcLen;
  logic              srcFirst_d;
  logic [DATA_W-1:0] srcShift_d;
  logic              curBit_d;
  logic [DATA_W-1:0] curShift_d;
  logic [CNT_W-1:0]  remain_d;

  ser_hold_reg #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_hold (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .wr_i     (holdWr),
    .rd_i     (holdRd),
    .data_i   (data_i),
    .mod_i    (data_mod_i),
    .msb_i    (msb_first_i),
    .data_o   (holdData),
    .mod_o    (holdMod),
    .msb_o    (holdMsb),
    .full_o   (holdFull)
  );

  assign inFire  = data_val_i && !holdFull;
  assign inLegal = legal_len(32'(data_mod_i), MIN_LEN);

  // In SHIFT the output is always valid, so "advance" reduces to ser_ready_i there
  // and is always true in IDLE.
  assign wordEnd  = (state_q == SHIFT) && (remain_q == '0) && ser_ready_i;
  assign slotFree = (state_q == IDLE) || wordEnd;
  assign stepBit  = (state_q == SHIFT) && (remain_q != '0) && ser_ready_i;

  // The queued word always goes before a newly arriving one to keep order.
  assign loadHold = slotFree && holdFull;
  assign loadIn   = slotFree && !holdFull && inFire && inLegal;

  // Illegal words are acknowledged but never stored, they only raise drop_o.
  assign holdWr = inFire && inLegal && !loadIn;
  assign holdRd = loadHold;

  assign srcData = loadHold ? holdData : data_i;
  assign srcMod  = loadHold ? holdMod  : data_mod_i;
  assign srcMsb  = loadHold ? holdMsb  : msb_first_i;
  assign srcLen  = CNT_W'(len_decode(32'(srcMod), DATA_W));

  // The shift register holds the word already advanced by one, so its edge bit
  // is always the next bit to present.
  assign srcFirst_d = srcMsb ? srcData[DATA_W-1] : srcData[0];
  assign srcShift_d = srcMsb ? (srcData << 1) : (srcData >> 1);
  assign curBit_d   = msb_q ? shift_q[DATA_W-1] : shift_q[0];
  assign curShift_d = msb_q ? (shift_q << 1) : (shift_q >> 1);
  assign remain_d   = remain_q - CNT_ONE;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      remain_q  <= '0;
      msb_q     <= 1'b0;
      serData_q <= 1'b0;
      serVal_q  <= 1'b0;
      serLast_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= inFire && !inLegal;
      if (loadHold || loadIn) begin
        state_q   <= SHIFT;
        shift_q   <= srcShift_d;
        remain_q  <= srcLen - CNT_ONE;
        msb_q     <= srcMsb;
        serData_q <= srcFirst_d;
        serVal_q  <= 1'b1;
        serLast_q <= (srcLen == CNT_ONE);
      end else if (stepBit) begin
        shift_q   <= curShift_d;
        remain_q  <= remain_d;
        serData_q <= curBit_d;
        serLast_q <= (remain_d == '0);
      end else if (wordEnd) begin
        state_q   <= IDLE;
        serData_q <= 1'b0;
        serVal_q  <= 1'b0;
        serLast_q <= 1'b0;
      end
    end
  end

  assign data_ready_o   = !holdFull;
  assign ser_data_o     = serData_q;
  assign ser_data_val_o = serVal_q;
  assign ser_last_o     = serLast_q;
  assign busy_o         = (state_q == SHIFT) || holdFull;
  assign drop_o         = drop_q;

endmodule

// File: tb/tb_serializer_stream.sv
// ---------------------------------------------------------------------------
// tb_serializer_stream
// Scoreboard bench for serializer_stream: each accepted word pushes its
// expected serial bits into a queue, a monitor pops and compares every bit
// the DUT presents.
// ---------------------------------------------------------------------------
module tb_serializer_stream;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic              clk_i;
  logic              arst_n_i;
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              msb_first_i;
  logic              data_val_i;
  logic              data_ready_o;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_last_o;
  logic              ser_ready_i;
  logic              busy_o;
  logic              drop_o;

  int checks = 0;
  int errors = 0;
  int expDrops = 0;
  int dropSeen = 0;
  int bitsPopped = 0;
  logic stallMode = 1'b0;
  logic [1:0] expQ[$];

  serializer_stream #(
    .DATA_W  (DATA_W),
    .MOD_W   (MOD_W),
    .MIN_LEN (3)
  ) dut (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .msb_first_i    (msb_first_i),
    .data_val_i     (data_val_i),
    .data_ready_o   (data_ready_o),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .ser_last_o     (ser_last_o),
    .ser_ready_i    (ser_ready_i),
    .busy_o         (busy_o),
    .drop_o         (drop_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: expected bit sequence of one accepted word.
  function automatic void pushWord(input logic [15:0] d, input logic [3:0] m, input logic msb);
    int len;
    logic bitv;
    len = (m == 4'd0) ? 16 : int'(m);
    if (len < 3) begin
      expDrops++;
    end else begin
      for (int i = 0; i < len; i++) begin
        bitv = msb ? d[15 - i] : d[i];
        expQ.push_back({bitv, (i == len - 1)});
      end
    end
  endfunction

  // Offers one word and returns #1 after the clock edge where it was accepted.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m, input logic msb);
    logic rdy;
    logic done;
    done = 1'b0;
    data_i      = d;
    data_mod_i  = m;
    msb_first_i = msb;
    data_val_i  = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_i);
      rdy = data_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) done = 1'b1;
    end
    data_val_i = 1'b0;
    if (done) pushWord(d, m, msb);
    else checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(posedge clk_i);
      #1;
      if (expQ.size() == 0 && !ser_data_val_o && !busy_o) done = 1'b1;
    end
    if (!done) begin
      checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  // Downstream ready: always 1, or random when stall mode is on.
  initial begin
    ser_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      ser_ready_i = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every presented bit must equal the queue head; it is popped when consumed.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk_i);
      if (arst_n_i) begin
        if (drop_o) dropSeen++;
        if (ser_data_val_o) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_bit", 32'd1, 32'd0);
          end else begin
            e = expQ[0];
            checkOutput("ser_data", 32'(ser_data_o), 32'(e[1]));
            checkOutput("ser_last", 32'(ser_last_o), 32'(e[0]));
            if (ser_ready_i) begin
              void'(expQ.pop_front());
              bitsPopped++;
            end
          end
        end
      end
    end
  end

  initial begin
    int base;
    logic seenLow;
    arst_n_i    = 1'b0;
    data_i      = '0;
    data_mod_i  = '0;
    msb_first_i = 1'b0;
    data_val_i  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_val", 32'(ser_data_val_o), 32'd0);
    checkOutput("rst_data", 32'(ser_data_o), 32'd0);
    checkOutput("rst_last", 32'(ser_last_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_drop", 32'(drop_o), 32'd0);
    checkOutput("rst_ready", 32'(data_ready_o), 32'd1);
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Case 1: full word MSB-first, first bit right after the accepting edge
    $display("[TB] case 1: A5C3 MSB-first");
    applyStimulus(16'hA5C3, 4'd0, 1'b1);
    checkOutput("latency_val", 32'(ser_data_val_o), 32'd1);
    checkOutput("latency_bit", 32'(ser_data_o), 32'd1);
    checkOutput("busy_active", 32'(busy_o), 32'd1);
    waitDrain();

    // Case 2: short LSB-first word, then an illegal length
    $display("[TB] case 2: short word and illegal length");
    applyStimulus(16'h000B, 4'd4, 1'b0);
    waitDrain();
    checkOutput("idle_val", 32'(ser_data_val_o), 32'd0);
    applyStimulus(16'h00FF, 4'd2, 1'b1);
    checkOutput("drop_pulse", 32'(drop_o), 32'd1);
    checkOutput("drop_busy", 32'(busy_o), 32'd0);
    checkOutput("drop_noval", 32'(ser_data_val_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("drop_end", 32'(drop_o), 32'd0);

    // Case 3: three words back to back must give 24 gap-free bits
    $display("[TB] case 3: back-to-back words");
    applyStimulus(16'h0005, 4'd3, 1'b0);
    seenLow = 1'b0;
    fork
      begin
        applyStimulus(16'hB800, 4'd5, 1'b1);
        applyStimulus(16'h1357, 4'd0, 1'b0);
      end
      begin
        for (int k = 0; k < 24; k++) begin
          @(negedge clk_i);
          checkOutput("no_gap", 32'(ser_data_val_o), 32'd1);
          if (!data_ready_o) seenLow = 1'b1;
        end
        @(negedge clk_i);
        checkOutput("burst_end", 32'(ser_data_val_o), 32'd0);
      end
    join
    checkOutput("ready_low_hold_full", 32'(seenLow), 32'd1);
    waitDrain();

    // Case 4: random downstream stalls
    $display("[TB] case 4: F00F with stalls");
    stallMode = 1'b1;
    applyStimulus(16'hF00F, 4'd0, 1'b1);
    waitDrain();
    stallMode = 1'b0;

    // Case 5: reset in the middle of a word
    $display("[TB] case 5: reset mid-word");
    base = bitsPopped;
    applyStimulus(16'h1234, 4'd0, 1'b1);
    for (int n = 0; n < 100 && bitsPopped < base + 7; n++) begin
      @(posedge clk_i);
      #1;
    end
    checkOutput("pre_reset_bits", 32'(bitsPopped - base), 32'd7);
    arst_n_i = 1'b0;
    #1;
    expQ.delete();
    checkOutput("mid_rst_val", 32'(ser_data_val_o), 32'd0);
    checkOutput("mid_rst_data", 32'(ser_data_o), 32'd0);
    checkOutput("mid_rst_last", 32'(ser_last_o), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("mid_rst_ready", 32'(data_ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus(16'h00F1, 4'd8, 1'b0);
    checkOutput("post_rst_first", 32'(ser_data_o), 32'd1);
    waitDrain();

    // Case 6: random words, lengths, orders and stalls
    $display("[TB] case 6: random traffic");
    stallMode = 1'b1;
    for (int w = 0; w < 150; w++) begin
      applyStimulus(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    waitDrain();
    stallMode = 1'b0;

    @(posedge clk_i);
    #1;
    checkOutput("drop_count", 32'(dropSeen), 32'(expDrops));
    checkOutput("final_busy", 32'(busy_o), 32'd0);
    checkOutput("final_ready", 32'(data_ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
